// File: rtl/cclimb_pkg.sv
// Shared types and defaults for the Crazy Climber download/reset controller.
package cclimb_pkg;

  typedef enum logic [1:0] {
    BOOT,
    LOAD,
    HOLD,
    RUN
  } dl_state_t;

  localparam int CCLIMB_ROM_SIZE    = 'hB000;
  localparam int CCLIMB_HOLD_CYCLES = 1024;

endpackage

// File: rtl/cclimb_hold_timer.sv
// Core-reset settle counter: load/reload wins over decrement; zero flags expiry.
// Decrement stops at zero, so a stalled HOLD state never wraps the count.
module cclimb_hold_timer (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        load,
  input  logic        dec,
  input  logic [15:0] load_val,
  output logic        zero
);

  logic [15:0] cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 16'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign zero = (cnt == 16'd0);

endmodule

// File: rtl/cclimb_dl_ctrl.sv
// ROM download forwarder and core-reset sequencer; dn_* is one cycle behind ioctl_wr.
// No back-pressure: one write per cycle; state-derived outputs lag the state by one edge.
module cclimb_dl_ctrl
  import cclimb_pkg::*;
#(
  parameter int ROM_SIZE    = CCLIMB_ROM_SIZE,
  parameter int HOLD_CYCLES = CCLIMB_HOLD_CYCLES
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        load_done,
  output logic        oor_err,
  output logic        short_err,
  output logic [16:0] byte_count
);

  localparam logic [24:0] ROM_LIM   = 25'(ROM_SIZE);
  localparam logic [16:0] ROM_CNT   = 17'(ROM_SIZE);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [16:0] CNT_MAX   = 17'h1FFFF;

  dl_state_t state;
  logic      dl_q;
  logic      done_q;
  logic      short_q;
  logic      rise;
  logic      fall;
  logic      in_range;
  logic      acc;
  logic      rej;
  logic      tmr_load;
  logic      tmr_dec;
  logic      tmr_zero;

  assign rise     = ioctl_download & ~dl_q;
  assign fall     = ~ioctl_download & dl_q;
  assign in_range = (ioctl_addr < ROM_LIM);
  assign acc      = ioctl_download & ioctl_wr & in_range;
  assign rej      = ioctl_download & ioctl_wr & ~in_range;

  // Entering HOLD from either side, or any user_reset while held/running, restarts the settle time.
  assign tmr_load = ((state == LOAD) & fall & (byte_count == ROM_CNT))
                  | (user_reset & ((state == HOLD) | (state == RUN)));
  assign tmr_dec  = (state == HOLD);

  cclimb_hold_timer u_hold_timer (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (HOLD_LOAD),
    .zero     (tmr_zero)
  );

  // dl_q resets high so a download already active when reset lifts is not taken as a new edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BOOT;
      dl_q       <= 1'b1;
      dn_addr    <= 16'd0;
      dn_data    <= 8'd0;
      dn_wr      <= 1'b0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      oor_err    <= 1'b0;
      short_err  <= 1'b0;
      byte_count <= 17'd0;
      done_q     <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      dl_q       <= ioctl_download;
      dn_wr      <= acc;
      core_reset <= (state != RUN);
      load_done  <= done_q;
      short_err  <= short_q;
      if (acc) begin
        dn_addr <= ioctl_addr[15:0];
        dn_data <= ioctl_dout;
      end
      if (rise) begin
        state      <= LOAD;
        byte_count <= acc ? 17'd1 : 17'd0;
        oor_err    <= rej;
        done_q     <= 1'b0;
        short_q    <= 1'b0;
      end else begin
        if (acc && byte_count != CNT_MAX) begin
          byte_count <= byte_count + 17'd1;
        end
        if (rej) begin
          oor_err <= 1'b1;
        end
        case (state)
          LOAD: begin
            if (fall) begin
              if (byte_count == ROM_CNT) begin
                state  <= HOLD;
                done_q <= 1'b1;
              end else begin
                state   <= BOOT;
                short_q <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (tmr_zero && !user_reset) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (user_reset) begin
              state <= HOLD;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cclimb_dl_ctrl.sv
// Randomized bench for cclimb_dl_ctrl with a per-edge write/flag model and scenario checks.
module tb_cclimb_dl_ctrl;

  localparam int ROM  = 'h600;
  localparam int HOLD = 100;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        user_reset = 1'b0;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset;
  logic        load_done;
  logic        oor_err;
  logic        short_err;
  logic [16:0] byte_count;

  int n_checks = 0;
  int n_fail   = 0;
  int g_wr_seen = 0;

  // Reference state: what the spec says the write path and counters must show after each edge.
  logic        m_prev_dl = 1'b0;
  logic        m_wr = 1'b0;
  logic        m_oor = 1'b0;
  logic [15:0] m_addr = 16'd0;
  logic [7:0]  m_data = 8'd0;
  int          m_count = 0;

  always #10 clk_sys = ~clk_sys;

  cclimb_dl_ctrl #(.ROM_SIZE(ROM), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .user_reset     (user_reset),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .core_reset     (core_reset),
    .load_done      (load_done),
    .oor_err        (oor_err),
    .short_err      (short_err),
    .byte_count     (byte_count)
  );

  task automatic model_reset();
    m_prev_dl = ioctl_download;
    m_wr = 1'b0; m_oor = 1'b0; m_addr = 16'd0; m_data = 8'd0; m_count = 0;
  endtask

  task automatic cycle(input logic dl, input logic wr, input logic [24:0] a,
                       input logic [7:0] d, input logic ur);
    ioctl_download = dl; ioctl_wr = wr; ioctl_addr = a; ioctl_dout = d; user_reset = ur;
    @(posedge clk_sys);
    #1;
    if (dl && !m_prev_dl) begin
      m_count = 0; m_oor = 1'b0;
    end
    m_prev_dl = dl;
    m_wr = dl && wr && (a < 25'(ROM));
    if (m_wr) begin
      m_addr = a[15:0]; m_data = d;
      if (m_count < 'h1FFFF) m_count++;
    end
    if (dl && wr && !(a < 25'(ROM))) m_oor = 1'b1;
    if (dn_wr) g_wr_seen++;
    n_checks++;
    if (dn_wr !== m_wr || dn_addr !== m_addr || dn_data !== m_data ||
        byte_count !== 17'(m_count) || oor_err !== m_oor) begin
      n_fail++;
      $display("FAIL fwd t=%0t got wr=%b a=%h d=%h cnt=%0d oor=%b want wr=%b a=%h d=%h cnt=%0d oor=%b",
               $time, dn_wr, dn_addr, dn_data, byte_count, oor_err,
               m_wr, m_addr, m_data, m_count, m_oor);
    end
  endtask

  task automatic idle(input logic dl, input logic ur);
    cycle(dl, 1'b0, 25'd0, 8'd0, ur);
  endtask

  task automatic send_image(input int start, input int n, input int oor_pos);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) idle(1'b1, 1'b0);
      if (i == oor_pos) cycle(1'b1, 1'b1, 25'h10000, 8'h5A, 1'b0);
      cycle(1'b1, 1'b1, 25'(start + i), 8'($urandom), 1'b0);
    end
  endtask

  // Edges after the current one until core_reset is first seen low; -1 if never within budget.
  task automatic measure_release(output int rel);
    rel = -1;
    for (int j = 1; j <= HOLD + 20; j++) begin
      idle(1'b0, 1'b0);
      if (core_reset === 1'b0) begin
        rel = j;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    n_checks++;
    if (core_reset !== 1'b1) begin n_fail++; $display("FAIL reset_core_reset got %b want 1", core_reset); end
    n_checks++;
    if (dn_wr !== 1'b0 || dn_addr !== 16'd0 || dn_data !== 8'd0) begin
      n_fail++; $display("FAIL reset_dn got wr=%b a=%h d=%h want 0", dn_wr, dn_addr, dn_data);
    end
    n_checks++;
    if (load_done !== 1'b0 || oor_err !== 1'b0 || short_err !== 1'b0 || byte_count !== 17'd0) begin
      n_fail++; $display("FAIL reset_flags got done=%b oor=%b short=%b cnt=%0d want 0", load_done, oor_err, short_err, byte_count);
    end
    reset_n = 1'b1;
    model_reset();
    repeat (5) idle(1'b0, 1'b0);
    n_checks++;
    if (core_reset !== 1'b1) begin n_fail++; $display("FAIL boot_idle_core_reset got %b want 1", core_reset); end
  endtask

  task automatic test_good_load();
    int seen0, rel;
    seen0 = g_wr_seen;
    send_image(0, ROM, -1);
    n_checks++;
    if (g_wr_seen - seen0 != ROM) begin n_fail++; $display("FAIL good_wr_count got %0d want %0d", g_wr_seen - seen0, ROM); end
    n_checks++;
    if (byte_count !== 17'(ROM)) begin n_fail++; $display("FAIL good_byte_count got %0d want %0d", byte_count, ROM); end
    idle(1'b0, 1'b0);
    measure_release(rel);
    n_checks++;
    if (rel != HOLD + 1) begin n_fail++; $display("FAIL good_release got %0d want %0d", rel, HOLD + 1); end
    n_checks++;
    if (load_done !== 1'b1 || short_err !== 1'b0) begin
      n_fail++; $display("FAIL good_flags got done=%b short=%b want done=1 short=0", load_done, short_err);
    end
  endtask

  task automatic test_out_of_range();
    int seen0, rel;
    seen0 = g_wr_seen;
    send_image(0, ROM, ROM / 2);
    n_checks++;
    if (g_wr_seen - seen0 != ROM) begin n_fail++; $display("FAIL oor_wr_count got %0d want %0d", g_wr_seen - seen0, ROM); end
    n_checks++;
    if (oor_err !== 1'b1 || byte_count !== 17'(ROM)) begin
      n_fail++; $display("FAIL oor_flags got oor=%b cnt=%0d want oor=1 cnt=%0d", oor_err, byte_count, ROM);
    end
    idle(1'b0, 1'b0);
    measure_release(rel);
    n_checks++;
    if (rel != HOLD + 1) begin n_fail++; $display("FAIL oor_release got %0d want %0d", rel, HOLD + 1); end
    n_checks++;
    if (oor_err !== 1'b1 || load_done !== 1'b1) begin
      n_fail++; $display("FAIL oor_sticky got oor=%b done=%b want 1 1", oor_err, load_done);
    end
  endtask

  task automatic test_user_reset_run();
    int rel;
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    n_checks++;
    if (core_reset !== 1'b1) begin n_fail++; $display("FAIL ur_run_rise got %b want 1", core_reset); end
    repeat (8) idle(1'b0, 1'b1);
    measure_release(rel);
    n_checks++;
    if (rel != HOLD + 1) begin n_fail++; $display("FAIL ur_run_release got %0d want %0d", rel, HOLD + 1); end
    n_checks++;
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL ur_run_done got %b want 1", load_done); end
  endtask

  task automatic test_redownload();
    int rel;
    cycle(1'b1, 1'b1, 25'd0, 8'($urandom), 1'b0);
    n_checks++;
    if (byte_count !== 17'd1 || oor_err !== 1'b0) begin
      n_fail++; $display("FAIL redl_clear got cnt=%0d oor=%b want cnt=1 oor=0", byte_count, oor_err);
    end
    idle(1'b1, 1'b0);
    n_checks++;
    if (core_reset !== 1'b1 || load_done !== 1'b0 || short_err !== 1'b0) begin
      n_fail++; $display("FAIL redl_rehold got rst=%b done=%b short=%b want 1 0 0", core_reset, load_done, short_err);
    end
    send_image(1, ROM - 1, -1);
    n_checks++;
    if (byte_count !== 17'(ROM)) begin n_fail++; $display("FAIL redl_count got %0d want %0d", byte_count, ROM); end
    idle(1'b0, 1'b0);
    measure_release(rel);
    n_checks++;
    if (rel != HOLD + 1 || load_done !== 1'b1) begin
      n_fail++; $display("FAIL redl_release got rel=%0d done=%b want rel=%0d done=1", rel, load_done, HOLD + 1);
    end
  endtask

  task automatic test_short_load();
    int rel;
    send_image(0, ROM / 2, -1);
    idle(1'b0, 1'b0);
    cycle(1'b0, 1'b1, 25'h10000, 8'hA5, 1'b0);
    cycle(1'b0, 1'b1, 25'h00010, 8'h3C, 1'b0);
    n_checks++;
    if (short_err !== 1'b1 || load_done !== 1'b0) begin
      n_fail++; $display("FAIL short_flags got short=%b done=%b want 1 0", short_err, load_done);
    end
    n_checks++;
    if (oor_err !== 1'b0 || byte_count !== 17'(ROM / 2)) begin
      n_fail++; $display("FAIL short_idle_wr got oor=%b cnt=%0d want 0 %0d", oor_err, byte_count, ROM / 2);
    end
    measure_release(rel);
    n_checks++;
    if (rel != -1 || core_reset !== 1'b1) begin n_fail++; $display("FAIL short_held got rel=%0d want -1", rel); end
  endtask

  task automatic test_user_reset_boot();
    int rel;
    repeat (10) idle(1'b0, 1'b1);
    measure_release(rel);
    n_checks++;
    if (rel != -1) begin n_fail++; $display("FAIL ur_boot_release got %0d want -1", rel); end
    n_checks++;
    if (short_err !== 1'b1 || load_done !== 1'b0) begin
      n_fail++; $display("FAIL ur_boot_flags got short=%b done=%b want 1 0", short_err, load_done);
    end
  endtask

  task automatic test_async_reset();
    int seen0, rel;
    send_image(0, 'h234, -1);
    ioctl_wr = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if (core_reset !== 1'b1 || dn_wr !== 1'b0 || dn_addr !== 16'd0 || dn_data !== 8'd0) begin
      n_fail++; $display("FAIL arst_outputs got rst=%b wr=%b a=%h d=%h want 1 0 0 0", core_reset, dn_wr, dn_addr, dn_data);
    end
    n_checks++;
    if (byte_count !== 17'd0 || oor_err !== 1'b0 || short_err !== 1'b0 || load_done !== 1'b0) begin
      n_fail++; $display("FAIL arst_flags got cnt=%0d oor=%b short=%b done=%b want 0", byte_count, oor_err, short_err, load_done);
    end
    @(posedge clk_sys);
    #1 reset_n = 1'b1;
    model_reset();
    seen0 = g_wr_seen;
    send_image('h234, ROM - 'h234, -1);
    n_checks++;
    if (g_wr_seen - seen0 != ROM - 'h234) begin
      n_fail++; $display("FAIL arst_wr_count got %0d want %0d", g_wr_seen - seen0, ROM - 'h234);
    end
    idle(1'b0, 1'b0);
    measure_release(rel);
    n_checks++;
    if (rel != -1 || load_done !== 1'b0) begin
      n_fail++; $display("FAIL arst_no_release got rel=%0d done=%b want -1 0", rel, load_done);
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_out_of_range();
    test_user_reset_run();
    test_redownload();
    test_short_load();
    test_user_reset_boot();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
